ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte to the mouse, for example 0xF4 (enable reporting) or 0xFF (reset), and reports whether the device acknowledged it. It sits beside the mouse receive path on the shared ps2_clk/ps2_data pins. The top level turns its active-high pull-down enables into open-drain drivers: pin = oe ? 1'b0 : 1'bz.

## Interface
Parameters:
- INHIBIT_CYCLES, 6500: host holds clock low this long before the request (100 µs at 65 MHz).
- START_TIMEOUT, 975000: maximum wait for the first device clock falling edge (15 ms).
- BIT_TIMEOUT, 130000: maximum gap between later falling edges (2 ms).
- FILTER_LEN, 8: number of identical consecutive samples before a filtered line changes.

Ports:
- clk  in  1: system clock (65 MHz).
- rst  in  1: synchronous, active-low reset.
- ps2_clk_in  in  1: raw PS/2 clock pin level.
- ps2_data_in  in  1: raw PS/2 data pin level.
- ps2_clk_oe  out  1: 1 = pull PS/2 clock low.
- ps2_data_oe  out  1: 1 = pull PS/2 data low.
- tx_data  in  8: byte to send.
- tx_valid  in  1: send request.
- tx_ready  out  1: block is idle and accepts a request.
- tx_done  out  1: one-cycle pulse when the transfer ends.
- tx_ack_ok  out  1: valid with tx_done; 1 = device pulled data low in the ack slot.
- tx_error  out  1: valid with tx_done; 1 = timeout or missing ack.

## Operation
- Both pins pass through a 2-FF synchronizer and then a glitch filter. The filtered level changes only after FILTER_LEN identical samples.
- A falling edge (fall) is the filtered clock going 1 -> 0.
- Request handshake: the request is accepted when tx_valid && tx_ready. The byte and its odd parity (~^tx_data) are latched. tx_ready drops on the next cycle.
- State IDLE: both oe = 0, tx_ready = 1. An accepted request moves to INHIBIT.
- State INHIBIT: clk_oe = 1 for INHIBIT_CYCLES cycles. Then data_oe = 1 (start bit) and clk_oe = 0; go to REQ.
- State REQ: wait for the first fall, then enter DATA with bit index 0.
- State DATA: on each fall, drive the next bit as data_oe = ~bit.
  - Falls 1..8 drive tx_data[0..7], LSB first.
  - Fall 9 drives parity.
  - Fall 10 releases data (stop bit = 1) and moves to ACK.
- State ACK: on the next fall, sample filtered data. Low sets ack_ok = 1, high sets ack_ok = 0. Go to WAIT_IDLE.
- State WAIT_IDLE: wait until filtered clock and data are both 1. Then go to DONE.
- State DONE: pulse tx_done for one cycle with ack_ok and error = ~ack_ok, then return to IDLE.
- Timeout: a 20-bit counter clears on every fall and on each state entry.
  - The limit is START_TIMEOUT in REQ and BIT_TIMEOUT in DATA, ACK and WAIT_IDLE.
  - On expiry: release both lines, go to DONE with ack_ok = 0 and error = 1.
- tx_valid while busy is ignored; the request is not queued.

## Timing
- Reset values: ps2_clk_oe = 0, ps2_data_oe = 0, tx_ready = 1, tx_done = 0, tx_ack_ok = 0, tx_error = 0. State = IDLE and all counters = 0.
- All outputs are registered.
- Accept -> clk_oe rises 1 cycle later and stays high for exactly INHIBIT_CYCLES cycles.
- data_oe rises on the same cycle that clk_oe falls.
- Pin fall -> data_oe update: 2 + FILTER_LEN + 1 cycles.
- tx_done -> tx_ready = 1 on the following cycle. A new request can then be accepted immediately.
- rst low mid-transfer releases both lines on that clock edge. No tx_done is issued.
- A fall and a timeout expiry on the same cycle: the fall wins.
- Device-initiated traffic while in IDLE is ignored. The receiver owns that traffic.

## Structure
- Package ps2_pkg holds:
  - the state enum: IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE, DONE;
  - the command constants CMD_RESET = 8'hFF, CMD_ENABLE = 8'hF4, RESP_ACK = 8'hFA;
  - the default timing constants.
- Sub-module ps2_line_filter (synchronizer plus glitch filter, parameter FILTER_LEN) is instantiated once per pin.

## Test plan
- Send 0xF4 to a device model clocking at 12.5 kHz that acks. Required: clk_oe high for 6500 cycles; data driven 0,0,1,0,1,1,1,1; parity 0; then release; tx_done with ack_ok = 1, error = 0.
- Send 0x00. Required: parity bit 1; ack_ok = 1.
- Device does not pull data low in the ack slot. Required: tx_done with ack_ok = 0, error = 1.
- Device never clocks. Required: tx_done with error = 1 exactly START_TIMEOUT cycles after REQ entry; both oe = 0; tx_ready = 1 on the next cycle.
- A 3-cycle low glitch on ps2_clk_in during DATA. Required: bit index unchanged; byte completes correctly.
- rst low at fall 5 of 0xA5. Required: both oe = 0 and tx_ready = 1 after that edge; no tx_done; a following 0xFF request completes with ack_ok = 1.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 host transmit path.
//   state_t        : transmitter FSM states
//   CMD_* / RESP_* : common mouse command and response bytes
//   DEF_*          : default timing, in 65 MHz system clock cycles
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      DATA,
      ACK,
      WAIT_IDLE,
      DONE
   } state_t;

   localparam logic [7:0] CMD_RESET  = 8'hFF;
   localparam logic [7:0] CMD_ENABLE = 8'hF4;
   localparam logic [7:0] RESP_ACK   = 8'hFA;

   localparam int DEF_INHIBIT_CYCLES = 6500;     // 100 us
   localparam int DEF_START_TIMEOUT  = 975000;   // 15 ms
   localparam int DEF_BIT_TIMEOUT    = 130000;   // 2 ms
   localparam int DEF_FILTER_LEN     = 8;

   // Width of the timeout counter; must hold DEF_START_TIMEOUT.
   localparam int TIMEOUT_W = 20;

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
// Brings one raw PS/2 pin into the clk domain and removes glitches.
//   clk   : system clock
//   rst   : synchronous, active-low reset
//   pin   : raw pin level (asynchronous)
//   level : filtered level; changes only after FILTER_LEN identical
//           synchronized samples that differ from the current level
// Latency from a pin change to level: 2 + FILTER_LEN cycles.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // The bus idles high, so everything resets to 1.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
         if (sync2 == level) begin
            // Any sample matching the current level restarts the run.
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter: sends one byte to the device and
// reports whether it was acknowledged.
//   clk, rst             : system clock, synchronous active-low reset
//   ps2_clk_in/data_in   : raw pin levels
//   ps2_clk_oe/data_oe   : 1 = pull the pin low (open drain at top level)
//   tx_data, tx_valid    : byte to send and request
//   tx_ready             : idle, request accepted when tx_valid && tx_ready
//   tx_done              : one-cycle pulse at the end of a transfer
//   tx_ack_ok, tx_error  : result, valid together with tx_done
// Handshake: a request is taken on the clock edge where tx_valid and
// tx_ready are both 1; tx_ready is low from the next cycle until the
// cycle after tx_done. tx_valid while busy is ignored, not queued.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
   parameter int BIT_TIMEOUT    = DEF_BIT_TIMEOUT,
   parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_ack_ok,
   output logic       tx_error
);

   localparam logic [TIMEOUT_W-1:0] INHIBIT_LAST = TIMEOUT_W'(INHIBIT_CYCLES - 1);
   localparam logic [TIMEOUT_W-1:0] START_LAST   = TIMEOUT_W'(START_TIMEOUT - 1);
   localparam logic [TIMEOUT_W-1:0] BIT_LAST     = TIMEOUT_W'(BIT_TIMEOUT - 1);

   logic                 clk_filt;
   logic                 data_filt;
   logic                 clk_prev;
   logic                 clk_fall;
   logic                 timed;
   logic                 to_expired;
   state_t               state;
   logic [TIMEOUT_W-1:0] inh_cnt;
   logic [TIMEOUT_W-1:0] to_cnt;
   logic [3:0]           bit_idx;
   logic [8:0]           shreg;     // {parity, data}, shifted out LSB first
   logic                 ack_seen;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk   (clk),
      .rst   (rst),
      .pin   (ps2_clk_in),
      .level (clk_filt)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
      .clk   (clk),
      .rst   (rst),
      .pin   (ps2_data_in),
      .level (data_filt)
   );

   assign clk_fall   = clk_prev & ~clk_filt;
   assign timed      = state inside {REQ, DATA, ACK, WAIT_IDLE};
   assign to_expired = (state == REQ) ? (to_cnt == START_LAST) : (to_cnt == BIT_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         clk_prev    <= 1'b1;
         inh_cnt     <= '0;
         to_cnt      <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         ack_seen    <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_ready    <= 1'b1;
         tx_done     <= 1'b0;
         tx_ack_ok   <= 1'b0;
         tx_error    <= 1'b0;
      end else begin
         clk_prev <= clk_filt;
         tx_done  <= 1'b0;

         // Timeout counter runs in the device-clocked states and restarts
         // on every falling edge of the filtered clock.
         if (timed) begin
            to_cnt <= clk_fall ? '0 : to_cnt + TIMEOUT_W'(1);
         end

         // A fall on the expiry cycle is serviced as a normal edge.
         if (timed && !clk_fall && to_expired) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b1;
            tx_ack_ok   <= 1'b0;
            tx_error    <= 1'b1;
            state       <= DONE;
         end else begin
            case (state)
               IDLE: begin
                  tx_ready <= 1'b1;
                  if (tx_valid && tx_ready) begin
                     shreg      <= {~^tx_data, tx_data};
                     tx_ready   <= 1'b0;
                     ps2_clk_oe <= 1'b1;
                     inh_cnt    <= '0;
                     state      <= INHIBIT;
                  end
               end

               INHIBIT: begin
                  if (inh_cnt == INHIBIT_LAST) begin
                     // Release clock and assert the start bit together.
                     ps2_clk_oe  <= 1'b0;
                     ps2_data_oe <= 1'b1;
                     inh_cnt     <= '0;
                     to_cnt      <= '0;
                     state       <= REQ;
                  end else begin
                     inh_cnt <= inh_cnt + TIMEOUT_W'(1);
                  end
               end

               REQ: begin
                  if (clk_fall) begin
                     bit_idx <= '0;
                     state   <= DATA;
                  end
               end

               DATA: begin
                  if (clk_fall) begin
                     if (bit_idx != 4'd9) begin
                        // Falls 1..9: eight data bits then parity.
                        ps2_data_oe <= ~shreg[0];
                        shreg       <= {1'b1, shreg[8:1]};
                        bit_idx     <= bit_idx + 4'd1;
                     end else begin
                        // Fall 10: stop bit is a released line.
                        ps2_data_oe <= 1'b0;
                        bit_idx     <= '0;
                        state       <= ACK;
                     end
                  end
               end

               ACK: begin
                  if (clk_fall) begin
                     ack_seen <= ~data_filt;
                     state    <= WAIT_IDLE;
                  end
               end

               WAIT_IDLE: begin
                  if (clk_filt && data_filt) begin
                     tx_done   <= 1'b1;
                     tx_ack_ok <= ack_seen;
                     tx_error  <= ~ack_seen;
                     state     <= DONE;
                  end
               end

               DONE: begin
                  tx_ack_ok <= 1'b0;
                  tx_error  <= 1'b0;
                  tx_ready  <= 1'b1;
                  to_cnt    <= '0;
                  ack_seen  <= 1'b0;
                  state     <= IDLE;
               end

               default: begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  tx_ready    <= 1'b1;
                  state       <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Bench for ps2_host_tx with a device model on wired-AND PS/2 lines.
// Timing parameters are shortened so every scenario fits a short run.
`timescale 1ns/1ps
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int IC   = 200;
   localparam int ST   = 3000;
   localparam int BT   = 600;
   localparam int FL   = 8;
   localparam int HALF = 50;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_done, tx_ack_ok, tx_error;

   // Device side of the bus; the pins are wired-AND with the host pulls.
   logic dev_clk  = 1'b1;
   logic dev_data = 1'b1;
   logic glitch   = 1'b0;
   assign ps2_clk_in  = dev_clk & ~ps2_clk_oe & ~glitch;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES (IC),
      .START_TIMEOUT  (ST),
      .BIT_TIMEOUT    (BT),
      .FILTER_LEN     (FL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_done     (tx_done),
      .tx_ack_ok   (tx_ack_ok),
      .tx_error    (tx_error)
   );

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [1:0]  exp_done_q[$];    // {ack_ok, error}
   logic [10:0] exp_frame_q[$];   // {stop, parity, data[7:0], start}
   logic [10:0] got_frame;
   event        frame_ev;
   bit          to_check = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic note_fail(input string name, input string detail);
      n_checks++;
      n_errors++;
      $display("FAIL %s: %s at %0t", name, detail, $time);
   endtask

   // ---------------- monitor: tx_done, inhibit, timeout ----------------
   initial begin
      logic [1:0] e;
      bit         done_prev   = 1'b0;
      bit         clk_oe_prev = 1'b0;
      bit         tracking    = 1'b0;
      int         inh_run     = 0;
      int         req_age     = 0;
      forever begin
         @(negedge clk);
         if (done_prev) check("ready_after_done", 32'(tx_ready), 32'd1);
         if (tracking) req_age++;
         if (ps2_clk_oe) inh_run++;
         if (clk_oe_prev && !ps2_clk_oe && rst) begin
            check("inhibit_len", 32'(inh_run), 32'(IC));
            check("start_bit_on_release", 32'(ps2_data_oe), 32'd1);
            req_age  = 0;
            tracking = 1'b1;
         end
         if (!ps2_clk_oe) inh_run = 0;
         if (tx_done) begin
            if (exp_done_q.size() == 0) begin
               note_fail("unexpected_done", $sformatf("ack_ok=%0b error=%0b", tx_ack_ok, tx_error));
            end else begin
               e = exp_done_q.pop_front();
               check("done_ack_ok", 32'(tx_ack_ok), 32'(e[1]));
               check("done_error", 32'(tx_error), 32'(e[0]));
            end
            check("done_lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
            if (to_check) begin
               check("timeout_latency", 32'(req_age), 32'(ST));
               to_check = 1'b0;
            end
            tracking = 1'b0;
         end
         done_prev   = tx_done;
         clk_oe_prev = ps2_clk_oe;
      end
   end

   // ---------------- monitor: frames seen by the device ----------------
   initial begin
      forever begin
         @(frame_ev);
         if (exp_frame_q.size() == 0) note_fail("unexpected_frame", $sformatf("frame=0x%0h", got_frame));
         else check("frame", 32'(got_frame), 32'(exp_frame_q.pop_front()));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [7:0] d);
      int w = 0;
      while (!tx_ready && w < 1000) begin
         @(negedge clk);
         w++;
      end
      if (!tx_ready) begin
         note_fail("send_ready_wait", "tx_ready never rose");
         return;
      end
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check("ready_drop", 32'(tx_ready), 32'd0);
   endtask

   // Device model: waits for the request, clocks 12 falls (request fall,
   // 8 data, parity, stop, ack), samples the line at the end of each low
   // phase, optionally acks, glitches the clock, or resets mid-frame.
   task automatic dev_run(input bit do_ack, input int abort_fall, input int glitch_fall, input bit lat_chk);
      logic [10:0] fr = '0;
      int          waited = 0;
      logic        prev_oe;
      int          lat;
      while (!(ps2_data_oe && !ps2_clk_oe) && waited < IC + 50) begin
         @(negedge clk);
         waited++;
      end
      if (!(ps2_data_oe && !ps2_clk_oe)) begin
         note_fail("dev_request_wait", "no start bit from host");
         return;
      end
      repeat (30) @(negedge clk);
      for (int f = 0; f < 12; f++) begin
         dev_clk = 1'b0;
         prev_oe = ps2_data_oe;
         lat     = 0;
         for (int i = 1; i <= HALF; i++) begin
            @(negedge clk);
            if (lat == 0 && ps2_data_oe !== prev_oe) lat = i;
         end
         if (lat_chk && f == 3) check("fall_to_data_latency", 32'(lat), 32'(2 + FL + 1));
         if (f == abort_fall) begin
            rst = 1'b0;
            @(negedge clk);
            check("abort_clk_oe", 32'(ps2_clk_oe), 32'd0);
            check("abort_data_oe", 32'(ps2_data_oe), 32'd0);
            check("abort_ready", 32'(tx_ready), 32'd1);
            rst     = 1'b1;
            dev_clk = 1'b1;
            return;
         end
         if (f < 11) fr[f] = ps2_data_in;
         dev_clk = 1'b1;
         if (f == 10 && do_ack) dev_data = 1'b0;
         if (f == 11) dev_data = 1'b1;
         for (int i = 1; i <= HALF; i++) begin
            @(negedge clk);
            if (f == glitch_fall && i == 20) glitch = 1'b1;
            if (f == glitch_fall && i == 23) glitch = 1'b0;
         end
      end
      got_frame = fr;
      ->frame_ev;
   endtask

   task automatic wait_drain(input int bound);
      int w = 0;
      while ((exp_done_q.size() != 0 || exp_frame_q.size() != 0) && w < bound) begin
         @(negedge clk);
         w++;
      end
      if (exp_done_q.size() != 0 || exp_frame_q.size() != 0)
         note_fail("drain_wait", $sformatf("pending done=%0d frame=%0d", exp_done_q.size(), exp_frame_q.size()));
      repeat (5) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("reset_data_oe", 32'(ps2_data_oe), 32'd0);
      check("reset_ready", 32'(tx_ready), 32'd1);
      check("reset_done", 32'(tx_done), 32'd0);
      check("reset_ack_ok", 32'(tx_ack_ok), 32'd0);
      check("reset_error", 32'(tx_error), 32'd0);
      rst = 1'b1;
      repeat (20) @(negedge clk);

      // 0xF4 acked: bits 0,0,1,0,1,1,1,1 then parity 0
      exp_frame_q.push_back({1'b1, 1'b0, 8'hF4, 1'b0});
      exp_done_q.push_back(2'b10);
      send(CMD_ENABLE);
      dev_run(1'b1, -1, -1, 1'b1);
      wait_drain(2000);

      // 0x00 acked: parity 1
      exp_frame_q.push_back({1'b1, 1'b1, 8'h00, 1'b0});
      exp_done_q.push_back(2'b10);
      send(8'h00);
      dev_run(1'b1, -1, -1, 1'b0);
      wait_drain(2000);

      // 0x3C, device leaves data high in the ack slot
      exp_frame_q.push_back({1'b1, 1'b1, 8'h3C, 1'b0});
      exp_done_q.push_back(2'b01);
      send(8'h3C);
      dev_run(1'b0, -1, -1, 1'b0);
      wait_drain(2000);

      // device never clocks
      exp_done_q.push_back(2'b01);
      to_check = 1'b1;
      send(CMD_ENABLE);
      wait_drain(IC + ST + 200);

      // 0x5B with a 3-cycle clock glitch after fall 3, plus a request while busy
      exp_frame_q.push_back({1'b1, 1'b0, 8'h5B, 1'b0});
      exp_done_q.push_back(2'b10);
      send(8'h5B);
      tx_data  = 8'h12;
      tx_valid = 1'b1;
      repeat (5) @(negedge clk);
      tx_valid = 1'b0;
      dev_run(1'b1, -1, 3, 1'b0);
      wait_drain(2000);

      // reset during fall 5 of 0xA5, then 0xFF completes
      send(8'hA5);
      dev_run(1'b1, 5, -1, 1'b0);
      repeat (50) @(negedge clk);
      exp_frame_q.push_back({1'b1, 1'b1, 8'hFF, 1'b0});
      exp_done_q.push_back(2'b10);
      send(CMD_RESET);
      dev_run(1'b1, -1, -1, 1'b0);
      wait_drain(2000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
